// File: rtl/sreg_pkg.sv
`default_nettype none
// ==== sreg_pkg: shared types and widths for the scalar register file port ====
// ==== Rev 1.0                                                              ====
package sreg_pkg;

    localparam int SREG_ADDR_W = 3;
    localparam int SREG_DATA_W = 16;
    localparam int SREG_BYTE_W = 8;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_WR_LO   = 3'd2,
        ST_WR_HI   = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_HOLD    = 3'd5,
        ST_RSP     = 3'd6
    } sreg_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sreg_access_ctrl.sv
`default_nettype none
// ==== sreg_access_ctrl: valid/ready requests to 8x16 register file access sequence ====
// ==== Rev 1.0                                                                      ====
module sreg_access_ctrl
    import sreg_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int READ_LAT  = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_op,
    input  logic [SREG_ADDR_W-1:0] req_addr,
    input  logic [SREG_DATA_W-1:0] req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [SREG_DATA_W-1:0] rsp_data,
    output logic [SREG_ADDR_W-1:0] Addr,
    output logic                   RD,
    output logic                   WR_l,
    output logic                   WR_h,
    output logic [SREG_BYTE_W-1:0] DataIn,
    input  logic [SREG_DATA_W-1:0] DataOut
);

    localparam int CNT_MAX = max3(SETUP_CYC, READ_LAT, HOLD_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_LD_SETUP  = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] c_LD_READ   = CNT_W'(READ_LAT);
    localparam logic [CNT_W-1:0] c_LD_HOLD   = CNT_W'(HOLD_CYC);

    sreg_state_e            r_state;
    sreg_state_e            w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_cnt_last;
    logic                   w_accept;

    logic                   r_op;
    logic [SREG_DATA_W-1:0] r_wdata;
    logic                   r_req_ready;
    logic                   r_rsp_valid;
    logic [SREG_DATA_W-1:0] r_rsp_data;
    logic [SREG_ADDR_W-1:0] r_addr;
    logic                   r_rd;
    logic                   r_wr_l;
    logic                   r_wr_h;
    logic [SREG_BYTE_W-1:0] r_din;

    logic                   w_op_nxt;
    logic [SREG_DATA_W-1:0] w_wdata_nxt;
    logic                   w_req_ready_nxt;
    logic                   w_rsp_valid_nxt;
    logic [SREG_DATA_W-1:0] w_rsp_data_nxt;
    logic [SREG_ADDR_W-1:0] w_addr_nxt;
    logic                   w_rd_nxt;
    logic                   w_wr_l_nxt;
    logic                   w_wr_h_nxt;
    logic [SREG_BYTE_W-1:0] w_din_nxt;

    assign w_cnt_last = (r_cnt == c_CNT_ONE);
    assign w_accept   = (r_state == ST_IDLE) && req_valid;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_op        <= OP_WRITE;
            r_wdata     <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_addr      <= '0;
            r_rd        <= 1'b0;
            r_wr_l      <= 1'b0;
            r_wr_h      <= 1'b0;
            r_din       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_op        <= w_op_nxt;
            r_wdata     <= w_wdata_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_addr      <= w_addr_nxt;
            r_rd        <= w_rd_nxt;
            r_wr_l      <= w_wr_l_nxt;
            r_wr_h      <= w_wr_h_nxt;
            r_din       <= w_din_nxt;
        end
    end

    // Timed states load the counter on entry and leave when it reaches 1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = c_LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_cnt_last) begin
                    if (r_op == OP_WRITE) begin
                        w_state_nxt = ST_WR_LO;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_RD_WAIT;
                        w_cnt_nxt   = c_LD_READ;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            ST_WR_LO: begin
                w_state_nxt = ST_WR_HI;
            end
            ST_WR_HI: begin
                w_state_nxt = ST_HOLD;
                w_cnt_nxt   = c_LD_HOLD;
            end
            ST_RD_WAIT: begin
                if (w_cnt_last) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = c_LD_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (w_cnt_last) begin
                    w_state_nxt = ST_RSP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        w_op_nxt        = r_op;
        w_wdata_nxt     = r_wdata;
        w_addr_nxt      = r_addr;
        w_din_nxt       = r_din;
        w_rsp_data_nxt  = r_rsp_data;
        w_req_ready_nxt = (w_state_nxt == ST_IDLE);
        w_rsp_valid_nxt = (w_state_nxt == ST_RSP);
        w_rd_nxt        = (w_state_nxt == ST_RD_WAIT);
        w_wr_l_nxt      = (w_state_nxt == ST_WR_LO);
        w_wr_h_nxt      = (w_state_nxt == ST_WR_HI);

        if (w_accept) begin
            w_op_nxt    = req_op;
            w_wdata_nxt = req_wdata;
            w_addr_nxt  = req_addr;
        end

        case (w_state_nxt)
            ST_WR_LO: w_din_nxt = r_wdata[SREG_BYTE_W-1:0];
            ST_WR_HI: w_din_nxt = r_wdata[SREG_DATA_W-1:SREG_BYTE_W];
            default:  w_din_nxt = r_din;
        endcase

        if ((r_state == ST_RD_WAIT) && w_cnt_last) begin
            w_rsp_data_nxt = DataOut;
        end else if (r_state == ST_WR_HI) begin
            w_rsp_data_nxt = r_wdata;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign Addr      = r_addr;
    assign RD        = r_rd;
    assign WR_l      = r_wr_l;
    assign WR_h      = r_wr_h;
    assign DataIn    = r_din;

endmodule
`default_nettype wire

// File: tb/tb_sreg_access_ctrl.sv
`default_nettype none
// ==== tb_sreg_access_ctrl: randomized bench with request-level timeline model ====
// ==== Rev 1.0                                                                  ====
module tb_sreg_access_ctrl;
    import sreg_pkg::*;

    localparam int NU   = 2;
    localparam int S0   = 1;
    localparam int L0   = 2;
    localparam int S1   = 2;
    localparam int L1   = 4;
    localparam int HOLD = 1;

    function automatic int p_setup(input int u);
        return (u == 0) ? S0 : S1;
    endfunction
    function automatic int p_rlat(input int u);
        return (u == 0) ? L0 : L1;
    endfunction

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req_valid [NU];
    logic        req_op    [NU];
    logic        rsp_ready [NU];
    logic [2:0]  req_addr  [NU];
    logic [15:0] req_wdata [NU];
    logic        req_ready [NU];
    logic        rsp_valid [NU];
    logic        rd        [NU];
    logic        wr_l      [NU];
    logic        wr_h      [NU];
    logic [2:0]  addr      [NU];
    logic [7:0]  din       [NU];
    logic [15:0] rsp_data  [NU];
    logic [15:0] dout      [NU];

    sreg_access_ctrl #(.SETUP_CYC(S0), .READ_LAT(L0), .HOLD_CYC(HOLD)) u_dut0 (
        .Clk(clk), .Rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .Addr(addr[0]), .RD(rd[0]), .WR_l(wr_l[0]), .WR_h(wr_h[0]),
        .DataIn(din[0]), .DataOut(dout[0])
    );

    sreg_access_ctrl #(.SETUP_CYC(S1), .READ_LAT(L1), .HOLD_CYC(HOLD)) u_dut1 (
        .Clk(clk), .Rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .Addr(addr[1]), .RD(rd[1]), .WR_l(wr_l[1]), .WR_h(wr_h[1]),
        .DataIn(din[1]), .DataOut(dout[1])
    );

    // Register file responder: byte writes on strobes, combinational read.
    logic [15:0] mem [NU][8];
    always @(posedge clk) begin
        for (int u = 0; u < NU; u++) begin
            if (wr_l[u]) mem[u][addr[u]][7:0]  <= din[u];
            if (wr_h[u]) mem[u][addr[u]][15:8] <= din[u];
        end
    end
    always_comb begin
        for (int u = 0; u < NU; u++) dout[u] = mem[u][addr[u]];
    end

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          k        [NU];
    int          acc_cyc  [NU];
    int          done     [NU];
    int          rdcnt    [NU];
    int          lat      [NU];
    bit          seen_rv  [NU];
    bit          fresh    [NU];
    logic        m_op     [NU];
    logic [2:0]  m_addr   [NU];
    logic [15:0] m_wd     [NU];
    logic [15:0] m_exp    [NU];
    logic [7:0]  m_din    [NU];
    logic [15:0] shadow   [NU][8];
    logic [15:0] last_rsp [NU];
    logic [15:0] last_dout[NU];
    logic [7:0]  obs_lo   [NU];
    logic [7:0]  obs_hi   [NU];
    bit          rr_force [NU];
    logic        rr_val   [NU];
    logic [15:0] init_u1_a3;

    task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s unit%0d @%0t: got %0h, want %0h", nm, u, $time, act, exp);
        end
    endtask

    task automatic tmo(input string nm, input int u);
        checks++;
        failures++;
        $display("FAIL timeout %s unit%0d @%0t: got no event, want event within bound", nm, u, $time);
    endtask

    // Model: each request is a timeline of k cycles after accept:
    // setup S, then 2 write cycles or L read cycles, then HOLD, then response until taken.
    always @(negedge clk) begin
        int s;
        int a;
        int rs;
        cyc++;
        for (int u = 0; u < NU; u++) begin
            s  = p_setup(u);
            a  = m_op[u] ? p_rlat(u) : 2;
            rs = s + a + HOLD + 1;
            if (!rst_n) begin
                k[u]      = 0;
                m_addr[u] = '0;
                m_din[u]  = '0;
                fresh[u]  = 1'b1;
            end else begin
                if (k[u] != 0 && !m_op[u] && k[u] == s + 1) m_din[u] = m_wd[u][7:0];
                if (k[u] != 0 && !m_op[u] && k[u] == s + 2) m_din[u] = m_wd[u][15:8];
                chk("req_ready", u, 32'(req_ready[u]), 32'(k[u] == 0));
                chk("rsp_valid", u, 32'(rsp_valid[u]), 32'(k[u] >= rs));
                chk("WR_l", u, 32'(wr_l[u]), 32'(k[u] != 0 && !m_op[u] && k[u] == s + 1));
                chk("WR_h", u, 32'(wr_h[u]), 32'(k[u] != 0 && !m_op[u] && k[u] == s + 2));
                chk("RD", u, 32'(rd[u]), 32'(k[u] != 0 && m_op[u] && k[u] > s && k[u] <= s + a));
                chk("Addr", u, 32'(addr[u]), 32'(m_addr[u]));
                chk("DataIn", u, 32'(din[u]), 32'(m_din[u]));
                if (k[u] >= rs) chk("rsp_data", u, 32'(rsp_data[u]), 32'(m_exp[u]));
                if (k[u] == 0 && fresh[u]) chk("rsp_data_reset", u, 32'(rsp_data[u]), 32'd0);

                if (rd[u]) begin
                    rdcnt[u]++;
                    last_dout[u] = dout[u];
                end
                if (wr_l[u]) obs_lo[u] = din[u];
                if (wr_h[u]) obs_hi[u] = din[u];
                if (rsp_valid[u] && !seen_rv[u] && k[u] != 0) begin
                    seen_rv[u] = 1'b1;
                    lat[u]     = cyc - acc_cyc[u];
                end
                if (rsp_valid[u]) last_rsp[u] = rsp_data[u];

                if (k[u] == 0) begin
                    if (req_valid[u]) begin
                        m_op[u]    = req_op[u];
                        m_addr[u]  = req_addr[u];
                        m_wd[u]    = req_wdata[u];
                        m_exp[u]   = (req_op[u] == OP_READ) ? shadow[u][req_addr[u]] : req_wdata[u];
                        k[u]       = 1;
                        fresh[u]   = 1'b0;
                        acc_cyc[u] = cyc;
                        rdcnt[u]   = 0;
                        seen_rv[u] = 1'b0;
                    end
                end else if (k[u] >= rs) begin
                    if (rsp_ready[u]) begin
                        k[u] = 0;
                        done[u]++;
                    end
                end else begin
                    if (!m_op[u] && k[u] == s + 1) shadow[u][m_addr[u]][7:0]  = m_wd[u][7:0];
                    if (!m_op[u] && k[u] == s + 2) shadow[u][m_addr[u]][15:8] = m_wd[u][15:8];
                    k[u]++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int u = 0; u < NU; u++)
                rsp_ready[u] = rr_force[u] ? rr_val[u] : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input int u, input logic op, input logic [2:0] a, input logic [15:0] d);
        int n;
        @(posedge clk);
        #1;
        req_valid[u] = 1'b1;
        req_op[u]    = op;
        req_addr[u]  = a;
        req_wdata[u] = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[u] && n < 50);
        if (!req_ready[u]) tmo("accept", u);
        @(posedge clk);
        #1;
        req_valid[u] = 1'b0;
        req_addr[u]  = 3'($urandom);
        req_wdata[u] = 16'($urandom);
    endtask

    task automatic txn(input int u, input logic op, input logic [2:0] a, input logic [15:0] d);
        int d0;
        int n;
        d0 = done[u];
        send(u, op, a, d);
        n = 0;
        while (done[u] == d0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done[u] == d0) tmo("response", u);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog @%0t: got no end of test, want end within bound", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int d0;
        int n;
        logic [15:0] v;
        for (int u = 0; u < NU; u++) begin
            req_valid[u] = 1'b0;
            req_op[u]    = 1'b0;
            req_addr[u]  = '0;
            req_wdata[u] = '0;
            rsp_ready[u] = 1'b0;
            rr_force[u]  = 1'b0;
            rr_val[u]    = 1'b1;
            done[u]      = 0;
            k[u]         = 0;
            m_op[u]      = 1'b0;
            for (int i = 0; i < 8; i++) begin
                v            = 16'($urandom);
                mem[u][i]   <= v;
                shadow[u][i] = v;
            end
        end
        init_u1_a3 = shadow[1][3];
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_req_ready", 0, 32'(req_ready[0]), 32'd1);
        chk("reset_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
        chk("reset_rsp_data", 0, 32'(rsp_data[0]), 32'd0);
        chk("reset_Addr", 0, 32'(addr[0]), 32'd0);
        chk("reset_DataIn", 0, 32'(din[0]), 32'd0);
        chk("reset_strobes", 0, {29'd0, rd[0], wr_l[0], wr_h[0]}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed byte-serial write then read back.
        txn(0, OP_WRITE, 3'd5, 16'hA55A);
        chk("wr_lo_byte", 0, 32'(obs_lo[0]), 32'h5A);
        chk("wr_hi_byte", 0, 32'(obs_hi[0]), 32'hA5);
        chk("wr_latency", 0, 32'(lat[0]), 32'd5);
        txn(0, OP_READ, 3'd5, 16'h0000);
        chk("rd_data_A55A", 0, 32'(last_rsp[0]), 32'hA55A);
        chk("rd_latency", 0, 32'(lat[0]), 32'd5);
        chk("rd_strobe_cycles", 0, 32'(rdcnt[0]), 32'd2);

        // Fill all addresses, read back in reverse.
        for (int i = 0; i < 8; i++) txn(0, OP_WRITE, 3'(i), 16'(16'h1111 * i));
        for (int i = 7; i >= 0; i--) begin
            txn(0, OP_READ, 3'(i), 16'($urandom));
            chk("reverse_read", 0, 32'(last_rsp[0]), 32'(16'h1111 * i));
        end

        // Response back-pressure: busy controller ignores new requests.
        rr_force[0] = 1'b1;
        rr_val[0]   = 1'b0;
        d0 = done[0];
        send(0, OP_READ, 3'd5, 16'h0000);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid[0] && n < 50);
        if (!rsp_valid[0]) tmo("rsp_valid_hold", 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            req_valid[0] = 1'b1;
            req_op[0]    = 1'($urandom);
            req_addr[0]  = 3'($urandom);
            @(negedge clk);
            chk("hold_rsp_valid", 0, 32'(rsp_valid[0]), 32'd1);
            chk("hold_rsp_data", 0, 32'(rsp_data[0]), 32'h5555);
            chk("hold_req_ready", 0, 32'(req_ready[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rr_val[0]    = 1'b1;
        n = 0;
        while (done[0] == d0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (done[0] == d0) tmo("hold_release", 0);
        @(negedge clk);
        chk("release_idle", 0, 32'(req_ready[0]), 32'd1);
        chk("release_one_rsp", 0, 32'(done[0] - d0), 32'd1);
        rr_force[0] = 1'b0;

        // Longer setup / read latency build.
        txn(1, OP_READ, 3'd3, 16'h0000);
        chk("u1_rd_latency", 1, 32'(lat[1]), 32'd8);
        chk("u1_rd_strobe_cycles", 1, 32'(rdcnt[1]), 32'd4);
        chk("u1_rd_data", 1, 32'(last_rsp[1]), 32'(init_u1_a3));
        chk("u1_rd_final_dout", 1, 32'(last_rsp[1]), 32'(last_dout[1]));

        // Randomized traffic on both controllers.
        fork
            begin
                for (int j = 0; j < 30; j++)
                    txn(0, 1'($urandom), 3'($urandom), 16'($urandom));
            end
            begin
                for (int j = 0; j < 20; j++)
                    txn(1, 1'($urandom), 3'($urandom), 16'($urandom));
            end
        join

        // Reset asserted during the high-byte write aborts the request.
        txn(0, OP_WRITE, 3'd2, 16'h1234);
        d0 = done[0];
        send(0, OP_WRITE, 3'd2, 16'hBEEF);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wr_h[0] && n < 20);
        if (!wr_h[0]) tmo("wr_hi_phase", 0);
        rst_n = 1'b0;
        #1;
        chk("abort_WR_h", 0, 32'(wr_h[0]), 32'd0);
        chk("abort_WR_l", 0, 32'(wr_l[0]), 32'd0);
        chk("abort_RD", 0, 32'(rd[0]), 32'd0);
        chk("abort_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 0, 32'(req_ready[0]), 32'd1);
        chk("post_reset_Addr", 0, 32'(addr[0]), 32'd0);
        repeat (10) @(negedge clk);
        chk("abort_no_rsp", 0, 32'(done[0] - d0), 32'd0);
        txn(0, OP_READ, 3'd2, 16'h0000);
        chk("abort_partial_write", 0, 32'(last_rsp[0]), 32'h12EF);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
